// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: pipeline (A) has priority,
// loader (B) is served within MAX_WAIT cycles. Optional DMEM_ALIGN_CHECK_EN adds a_misalign.
module dmem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_rd,
    input  logic          a_wr,
    input  logic          a_word,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_stall,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_word,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic          mem_word,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic          a_misalign
`endif
);

    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_A    = 2'd1,
        RSEL_B    = 2'd2
    } rsel_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic       a_act;
    logic       gnt_a, gnt_b;
    logic [3:0] wait_cnt, wait_nxt;
    logic       sel_rd, sel_wr, sel_word, misalign;
    rsel_t      rsel, rsel_nxt;

    assign a_act = a_rd | a_wr;

    // Grant selection; reset forces no grant so every enable and b_gnt drop to 0.
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        wait_nxt = '0;
        if (rst_n) begin
            if (a_act && b_req) begin
                if (wait_cnt < MAX_W) begin
                    gnt_a    = 1'b1;
                    wait_nxt = wait_cnt + 4'd1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else if (a_act) begin
                gnt_a = 1'b1;
            end else if (b_req) begin
                gnt_b = 1'b1;
            end
        end
    end

    assign b_gnt   = gnt_b;
    assign a_stall = gnt_b & a_act;

    always_comb begin
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_word  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_a) begin
            sel_wr    = a_wr;
            sel_rd    = a_rd & ~a_wr;
            sel_word  = a_word;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (gnt_b) begin
            sel_wr    = b_we;
            sel_rd    = ~b_we;
            sel_word  = b_word;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = (gnt_a | gnt_b) & sel_word & mem_addr[0];
`else
        misalign = 1'b0;
`endif
    end

    assign mem_rd_en = sel_rd & ~misalign;
    assign mem_wr_en = sel_wr & ~misalign;
    assign mem_word  = sel_word;

`ifdef DMEM_ALIGN_CHECK_EN
    assign a_misalign = gnt_a & misalign;
`endif

    always_comb begin
        rsel_nxt = RSEL_NONE;
        if (mem_rd_en)
            rsel_nxt = gnt_a ? RSEL_A : RSEL_B;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rsel     <= RSEL_NONE;
        end else begin
            wait_cnt <= wait_nxt;
            rsel     <= rsel_nxt;
        end
    end

    assign a_rvalid = (rsel == RSEL_A);
    assign b_rvalid = (rsel == RSEL_B);
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (MAX_WAIT = 4).
// Build with +define+DMEM_ALIGN_CHECK_EN to also exercise the misalignment check.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_rd, a_wr, a_word;
    logic [15:0] a_addr, a_wdata;
    logic        a_stall, a_rvalid;
    logic [15:0] a_rdata;
    logic        b_req, b_we, b_word;
    logic [15:0] b_addr, b_wdata;
    logic        b_gnt, b_rvalid;
    logic [15:0] b_rdata;
    logic        mem_rd_en, mem_wr_en, mem_word;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        a_misalign;
`endif

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_rd(a_rd), .a_wr(a_wr), .a_word(a_word), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_word(b_word), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_word(mem_word),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ALIGN_CHECK_EN
        , .a_misalign(a_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_rd = 0; a_wr = 0; a_word = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_word = 0; b_addr = '0; b_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; a_rd = 1; a_addr = 16'h0010; mem_rdata = 16'hFFFF;
        #1;
        checks++;
        if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
        checks++;
        if (a_stall !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL reset_stall_gnt got %b%b want 00", a_stall, b_gnt); end
        @(posedge clk); #1;
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rvalid got %b/%h want 0/0000", a_rvalid, a_rdata); end
        checks++;
        if (dut.wait_cnt !== 4'd0) begin errors++; $display("FAIL reset_wait_cnt got %0d want 0", dut.wait_cnt); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        #1;
        checks++;
        if (mem_rd_en !== 0 || mem_wr_en !== 0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++; $display("FAIL idle_outputs got rd=%b wr=%b addr=%h wdata=%h want 0", mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_a_read();
        @(negedge clk);
        a_rd = 1; a_addr = 16'h0020;
        #1;
        checks++;
        if (mem_rd_en !== 1 || mem_wr_en !== 0 || mem_addr !== 16'h0020) begin
            errors++; $display("FAIL a_read_issue got rd=%b wr=%b addr=%h want 1/0/0020", mem_rd_en, mem_wr_en, mem_addr);
        end
        @(posedge clk); #1;
        a_rd = 0; a_addr = '0; mem_rdata = 16'hBEEF;
        #1;
        checks++;
        if (a_rvalid !== 1 || a_rdata !== 16'hBEEF) begin errors++; $display("FAIL a_read_return got %b/%h want 1/beef", a_rvalid, a_rdata); end
        checks++;
        if (b_rvalid !== 0 || b_rdata !== 16'h0) begin errors++; $display("FAIL a_read_b_quiet got %b/%h want 0/0000", b_rvalid, b_rdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_b_write();
        @(negedge clk);
        b_req = 1; b_we = 1; b_addr = 16'h0100; b_wdata = 16'h1234; b_word = 1;
        #1;
        checks++;
        if (b_gnt !== 1 || a_stall !== 0) begin errors++; $display("FAIL b_write_gnt got gnt=%b stall=%b want 1/0", b_gnt, a_stall); end
        checks++;
        if (mem_wr_en !== 1 || mem_rd_en !== 0 || mem_word !== 1 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) begin
            errors++; $display("FAIL b_write_mem got wr=%b rd=%b word=%b addr=%h wdata=%h want 1/0/1/0100/1234",
                               mem_wr_en, mem_rd_en, mem_word, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (a_rvalid !== 0 || b_rvalid !== 0) begin errors++; $display("FAIL b_write_no_rvalid got %b%b want 00", a_rvalid, b_rvalid); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_a_write_priority();
        @(negedge clk);
        a_rd = 1; a_wr = 1; a_word = 1; a_addr = 16'h0044; a_wdata = 16'h5A5A;
        #1;
        checks++;
        if (mem_wr_en !== 1 || mem_rd_en !== 0 || mem_word !== 1 || mem_wdata !== 16'h5A5A) begin
            errors++; $display("FAIL a_rdwr_is_write got wr=%b rd=%b word=%b wdata=%h want 1/0/1/5a5a", mem_wr_en, mem_rd_en, mem_word, mem_wdata);
        end
        @(posedge clk); #1;
        mem_rdata = 16'h7777;
        #1;
        checks++;
        if (a_rvalid !== 0 || a_rdata !== 16'h0) begin errors++; $display("FAIL a_write_no_rvalid got %b/%h want 0/0000", a_rvalid, a_rdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [15:0] exp_addr;
        @(negedge clk);
        a_rd = 1; a_addr = 16'h0030; b_req = 1; b_we = 0; b_addr = 16'h0200;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            mem_rdata = 16'hC000 + 16'(i);
            #1;
            exp_addr = (i == 4) ? 16'h0200 : 16'h0030;
            checks++;
            if (b_gnt !== (i == 4) || a_stall !== (i == 4)) begin
                errors++; $display("FAIL starve_gnt cyc%0d got gnt=%b stall=%b want %b", i, b_gnt, a_stall, (i == 4));
            end
            checks++;
            if (mem_addr !== exp_addr || mem_rd_en !== 1) begin
                errors++; $display("FAIL starve_addr cyc%0d got %h rd=%b want %h rd=1", i, mem_addr, mem_rd_en, exp_addr);
            end
            if (i > 0) begin
                checks++;
                if (a_rvalid !== (i != 5) || b_rvalid !== (i == 5)) begin
                    errors++; $display("FAIL starve_rvalid cyc%0d got a=%b b=%b want a=%b b=%b", i, a_rvalid, b_rvalid, (i != 5), (i == 5));
                end
            end
            if (i == 5) begin
                checks++;
                if (b_rdata !== 16'hC005 || a_rdata !== 16'h0) begin
                    errors++; $display("FAIL starve_b_rdata got b=%h a=%h want c005/0000", b_rdata, a_rdata);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_alternating();
        @(negedge clk);
        a_rd = 1; a_addr = 16'h0002;
        #1;
        checks++;
        if (mem_addr !== 16'h0002 || mem_rd_en !== 1) begin errors++; $display("FAIL alt_a_issue got %h rd=%b want 0002 rd=1", mem_addr, mem_rd_en); end
        @(negedge clk);
        a_rd = 0; a_addr = '0; b_req = 1; b_we = 0; b_addr = 16'h0004; mem_rdata = 16'h1111;
        #1;
        checks++;
        if (b_gnt !== 1 || a_stall !== 0 || mem_addr !== 16'h0004 || mem_rd_en !== 1) begin
            errors++; $display("FAIL alt_b_issue got gnt=%b stall=%b addr=%h rd=%b want 1/0/0004/1", b_gnt, a_stall, mem_addr, mem_rd_en);
        end
        checks++;
        if (a_rvalid !== 1 || a_rdata !== 16'h1111 || b_rvalid !== 0) begin
            errors++; $display("FAIL alt_a_return got a=%b/%h b=%b want 1/1111/0", a_rvalid, a_rdata, b_rvalid);
        end
        @(negedge clk);
        b_req = 0; b_addr = '0; mem_rdata = 16'h2222;
        #1;
        checks++;
        if (b_rvalid !== 1 || b_rdata !== 16'h2222 || a_rvalid !== 0 || a_rdata !== 16'h0) begin
            errors++; $display("FAIL alt_b_return got b=%b/%h a=%b/%h want 1/2222/0/0000", b_rvalid, b_rdata, a_rvalid, a_rdata);
        end
        checks++;
        if (b_gnt !== 0) begin errors++; $display("FAIL alt_gnt_without_req got %b want 0", b_gnt); end
        @(negedge clk);
        idle_inputs();
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        @(negedge clk);
        a_rd = 1; a_word = 1; a_addr = 16'h0003;
        #1;
        checks++;
        if (a_misalign !== 1 || mem_rd_en !== 0 || mem_wr_en !== 0) begin
            errors++; $display("FAIL misalign_issue got mis=%b rd=%b wr=%b want 1/0/0", a_misalign, mem_rd_en, mem_wr_en);
        end
        @(posedge clk); #1;
        a_rd = 0; a_word = 0; a_addr = '0; mem_rdata = 16'h9999;
        #1;
        checks++;
        if (a_rvalid !== 0 || a_misalign !== 0) begin errors++; $display("FAIL misalign_no_rvalid got rv=%b mis=%b want 0/0", a_rvalid, a_misalign); end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_a_read();
        test_b_write();
        test_a_write_priority();
        test_starvation();
        test_alternating();
`ifdef DMEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (port A) and the program/data loader (port B).
- Port A has fixed priority. A wait counter guarantees port B is served within MAX_WAIT cycles, stalling the pipeline for one cycle when it is.
- Routes the 1-cycle-latency read data back to whichever port issued the read.
- Sits between the MEM stage and the DataMemory instance.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_WAIT, 4, max consecutive cycles port B may be denied while requesting (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- a_rd  in  1  pipeline read request (MemRd)
- a_wr  in  1  pipeline write request (MemWr)
- a_word  in  1  1 = 16-bit access, 0 = byte access
- a_addr  in  AW  pipeline address (ALU result)
- a_wdata  in  DW  pipeline store data
- a_stall  out  1  pipeline must hold MEM/WB this cycle; A not issued
- a_rvalid  out  1  a_rdata valid (registered)
- a_rdata  out  DW  read data for port A
- b_req  in  1  loader request; held until b_gnt
- b_we  in  1  loader write
- b_word  in  1  loader access size
- b_addr  in  AW  loader address
- b_wdata  in  DW  loader write data
- b_gnt  out  1  loader request issued this cycle (combinational)
- b_rvalid  out  1  b_rdata valid (registered)
- b_rdata  out  DW  read data for port B
- mem_rd_en  out  1  to DataMemory rdEnable
- mem_wr_en  out  1  to DataMemory wrEnable
- mem_word  out  1  to DataMemory size select
- mem_addr  out  AW  to DataMemory address
- mem_wdata  out  DW  to DataMemory in
- mem_rdata  in  DW  DataMemory out, valid the cycle after mem_rd_en

Behaviour:
- a_act = a_rd | a_wr. If a_rd and a_wr are both high, A is treated as a write.
- Grant selection is combinational from a_act, b_req and wait_cnt (4-bit register):
  - a_act and b_req and wait_cnt < MAX_WAIT: grant A; wait_cnt <= wait_cnt + 1; b_gnt = 0.
  - a_act and b_req and wait_cnt == MAX_WAIT: grant B; a_stall = 1; b_gnt = 1; wait_cnt <= 0.
  - a_act only: grant A; wait_cnt <= 0.
  - b_req only: grant B; b_gnt = 1; wait_cnt <= 0.
  - neither: no access; all mem enables 0; wait_cnt <= 0.
- mem_* outputs carry the granted port's fields. When nothing is granted, mem_addr and mem_wdata are 0.
- Read-return tracking:
  - rsel register (2 bits: none / A / B) <= granted port if that access is a read, else none.
  - Next cycle: a_rvalid = (rsel == A), b_rvalid = (rsel == B).
  - The matching rdata is mem_rdata; the non-selected rdata is 0.
  - Read latency is exactly 1 cycle for both ports.
- Back-to-back reads on alternating ports are legal. rsel updates every cycle, so no return is lost.
- a_stall is asserted only in the starvation-grant cycle. The next cycle A re-presents the same request and wins, since wait_cnt = 0.
- b_gnt is never high when b_req is low.
- Reset (rst_n low at a rising edge):
  - wait_cnt = 0, rsel = none.
  - a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0.
  - A read issued in the cycle reset is sampled produces no rvalid.
- Combinational outputs with rst_n low: mem enables, b_gnt and a_stall are forced to 0.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output a_misalign (1 bit).
  - A word access by port A with a_addr[0] = 1 suppresses mem_rd_en and mem_wr_en for that cycle.
  - a_misalign pulses high for that cycle (combinational). rsel = none, so no a_rvalid follows.
  - The suppressed cycle still counts as an A grant for wait_cnt.
  - Port B misaligned word accesses are likewise suppressed, still granted (b_gnt = 1), with no b_rvalid.
- Undefined:
  - No a_misalign port. Addresses pass through unchanged; alignment is DataMemory's concern.

Test Plan:
- Reset: rst_n = 0 with a_rd = 1, a_addr = 0x0010 -> mem_rd_en = 0, a_rvalid = 0 next cycle, wait_cnt = 0.
- A read alone: a_rd = 1, a_addr = 0x0020, mem_rdata = 0xBEEF next cycle -> mem_rd_en = 1, mem_addr = 0x0020 in cycle N; a_rvalid = 1, a_rdata = 0xBEEF in N+1; b_rvalid = 0.
- B write alone: b_req = 1, b_we = 1, b_addr = 0x0100, b_wdata = 0x1234 -> b_gnt = 1, mem_wr_en = 1, mem_addr = 0x0100, mem_wdata = 0x1234 in the same cycle.
- Starvation, MAX_WAIT = 4: a_rd and b_req held high for 6 cycles -> cycles 0-3 grant A (b_gnt = 0); cycle 4 b_gnt = 1, a_stall = 1, mem_addr = b_addr; cycle 5 grants A again.
- Alternating reads: A read at 0x0002, then B read at 0x0004 on consecutive cycles -> a_rvalid in cycle N+1, b_rvalid in cycle N+2, each carrying its own mem_rdata.
- With DMEM_ALIGN_CHECK_EN: a_rd = 1, a_word = 1, a_addr = 0x0003 -> a_misalign = 1, mem_rd_en = 0, no a_rvalid next cycle.
